// File: rtl/sw_score_collector_if.sv
// Score-beat input stream and alignment-result output stream of the SW score collector.
// master: the side that feeds beats and consumes results (array tail / downstream).
// slave: the collector itself.
interface sw_score_collector_if #(
  parameter int SCORE_W = 16,
  parameter int ROW_W   = 10,
  parameter int COL_W   = 10
);
  logic               io_in_valid;
  logic               io_in_ready;
  logic [SCORE_W-1:0] io_in_score;
  logic               io_in_eor;
  logic               io_in_eoa;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [SCORE_W-1:0] io_out_score;
  logic [ROW_W-1:0]   io_out_row;
  logic [COL_W-1:0]   io_out_col;
  logic               io_out_found;
  logic               io_out_ovf;
  logic               io_busy;

  modport master (
    output io_in_valid, io_in_score, io_in_eor, io_in_eoa, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_score, io_out_row, io_out_col,
           io_out_found, io_out_ovf, io_busy
  );

  modport slave (
    input  io_in_valid, io_in_score, io_in_eor, io_in_eoa, io_out_ready,
    output io_in_ready, io_out_valid, io_out_score, io_out_row, io_out_col,
           io_out_found, io_out_ovf, io_busy
  );
endinterface

// File: rtl/sw_score_collector.sv
// Tracks the maximum Smith-Waterman cell score and its (row, col) over one alignment.
// Latency: result valid the cycle after the eoa beat is accepted.
// Backpressure: input stalls (ready low) while a result waits for io_out_ready.
module sw_score_collector #(
  parameter int SCORE_W = 16,
  parameter int ROW_W   = 10,
  parameter int COL_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  sw_score_collector_if.slave io
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [SCORE_W-1:0] max_q;
  logic [ROW_W-1:0]   max_row_q;
  logic [COL_W-1:0]   max_col_q;
  logic               ovf_q;

  logic               accept;
  logic [SCORE_W-1:0] cur_max;
  logic [ROW_W-1:0]   cur_row;
  logic [COL_W-1:0]   cur_col;
  logic               take;

  // Ready depends on state only, so a pending result blocks the stream.
  assign io.io_in_ready = (state_q != RESULT);
  assign accept         = io.io_in_valid && io.io_in_ready;

  // Comparison baseline: a fresh alignment starts from max 0 at (0,0).
  always_comb begin
    cur_max = max_q;
    cur_row = max_row_q;
    cur_col = max_col_q;
    if (state_q == IDLE) begin
      cur_max = '0;
      cur_row = '0;
      cur_col = '0;
    end
    // Strictly greater, so the first occurrence of a tie is kept.
    take = (io.io_in_score > cur_max);
  end

  // Next-state logic; eoa wins over eor on a combined beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = io.io_in_eoa ? RESULT : COLLECT;
      end
      COLLECT: begin
        if (accept && io.io_in_eoa) state_d = RESULT;
      end
      RESULT: begin
        if (io.io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Position counters, running maximum and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      col_q     <= '0;
      max_q     <= '0;
      max_row_q <= '0;
      max_col_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        if (take) begin
          max_q     <= io.io_in_score;
          max_row_q <= row_q;
          max_col_q <= col_q;
        end else begin
          max_q     <= cur_max;
          max_row_q <= cur_row;
          max_col_q <= cur_col;
        end
        // Indices saturate at all-ones; a blocked increment is remembered in ovf.
        if (io.io_in_eor) begin
          col_q <= '0;
          if (&row_q) ovf_q <= 1'b1;
          else        row_q <= row_q + ROW_W'(1);
        end else begin
          if (&col_q) ovf_q <= 1'b1;
          else        col_q <= col_q + COL_W'(1);
        end
      end
      // Result consumed: next alignment begins at (0,0) with a clean ovf.
      if ((state_q == RESULT) && io.io_out_ready) begin
        row_q <= '0;
        col_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign io.io_out_valid = (state_q == RESULT);
  assign io.io_busy      = (state_q == COLLECT);
  assign io.io_out_score = max_q;
  assign io.io_out_row   = max_row_q;
  assign io.io_out_col   = max_col_q;
  assign io.io_out_found = (max_q != '0);
  assign io.io_out_ovf   = ovf_q;

endmodule

// File: tb/tb_sw_score_collector.sv
// Directed bench for sw_score_collector: two instances (COL_W=10 and COL_W=2)
// receive identical stimulus; expected values are hand-computed per step.
module tb_sw_score_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_score;
  logic        in_eor;
  logic        in_eoa;
  logic        out_ready;

  int tests  = 0;
  int failed = 0;

  sw_score_collector_if #(.SCORE_W(16), .ROW_W(10), .COL_W(10)) ifa ();
  sw_score_collector_if #(.SCORE_W(16), .ROW_W(10), .COL_W(2))  ifb ();

  assign ifa.io_in_valid  = in_valid;
  assign ifa.io_in_score  = in_score;
  assign ifa.io_in_eor    = in_eor;
  assign ifa.io_in_eoa    = in_eoa;
  assign ifa.io_out_ready = out_ready;
  assign ifb.io_in_valid  = in_valid;
  assign ifb.io_in_score  = in_score;
  assign ifb.io_in_eor    = in_eor;
  assign ifb.io_in_eoa    = in_eoa;
  assign ifb.io_out_ready = out_ready;

  sw_score_collector #(.SCORE_W(16), .ROW_W(10), .COL_W(10)) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (ifa.slave)
  );

  sw_score_collector #(.SCORE_W(16), .ROW_W(10), .COL_W(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (ifb.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted-or-offered beat; returns 1 time unit after the clock edge.
  task automatic beat(input logic [15:0] s, input logic eor, input logic eoa);
    in_valid = 1'b1;
    in_score = s;
    in_eor   = eor;
    in_eoa   = eoa;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_eor   = 1'b0;
    in_eoa   = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_score  = '0;
    in_eor    = 1'b0;
    in_eoa    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(ifa.io_in_ready), 1);
    check("rst_out_valid", 32'(ifa.io_out_valid), 0);
    check("rst_busy", 32'(ifa.io_busy), 0);
    check("rst_score", 32'(ifa.io_out_score), 0);
    check("rst_pos", 32'({ifa.io_out_row, ifa.io_out_col}), 0);
    check("rst_found_ovf", 32'({ifa.io_out_found, ifa.io_out_ovf}), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("post_rst_in_ready", 32'(ifa.io_in_ready), 1);

    // 2x3 matrix 1,4,2 / 3,9,0
    beat(16'd1, 1'b0, 1'b0);
    check("m23_busy", 32'(ifa.io_busy), 1);
    check("m23_no_valid", 32'(ifa.io_out_valid), 0);
    beat(16'd4, 1'b0, 1'b0);
    beat(16'd2, 1'b1, 1'b0);
    beat(16'd3, 1'b0, 1'b0);
    beat(16'd9, 1'b0, 1'b0);
    beat(16'd0, 1'b1, 1'b1);
    check("m23_valid", 32'(ifa.io_out_valid), 1);
    check("m23_score", 32'(ifa.io_out_score), 9);
    check("m23_row", 32'(ifa.io_out_row), 1);
    check("m23_col", 32'(ifa.io_out_col), 1);
    check("m23_found", 32'(ifa.io_out_found), 1);
    check("m23_ovf", 32'(ifa.io_out_ovf), 0);
    check("m23_in_ready", 32'(ifa.io_in_ready), 0);
    check("m23_busy_res", 32'(ifa.io_busy), 0);
    handshake();
    check("m23_done_valid", 32'(ifa.io_out_valid), 0);
    check("m23_done_ready", 32'(ifa.io_in_ready), 1);

    // Tie: 5,7,7 single row, last beat carries eor and eoa together
    beat(16'd5, 1'b0, 1'b0);
    beat(16'd7, 1'b0, 1'b0);
    beat(16'd7, 1'b1, 1'b1);
    check("tie_valid", 32'(ifa.io_out_valid), 1);
    check("tie_score", 32'(ifa.io_out_score), 7);
    check("tie_row", 32'(ifa.io_out_row), 0);
    check("tie_col", 32'(ifa.io_out_col), 1);
    handshake();

    // All-zero 2x2
    beat(16'd0, 1'b0, 1'b0);
    beat(16'd0, 1'b1, 1'b0);
    beat(16'd0, 1'b0, 1'b0);
    beat(16'd0, 1'b1, 1'b1);
    check("zero_valid", 32'(ifa.io_out_valid), 1);
    check("zero_score", 32'(ifa.io_out_score), 0);
    check("zero_pos", 32'({ifa.io_out_row, ifa.io_out_col}), 0);
    check("zero_found", 32'(ifa.io_out_found), 0);
    handshake();

    // Pending result under backpressure, input beats offered meanwhile
    beat(16'd3, 1'b0, 1'b0);
    beat(16'd8, 1'b0, 1'b1);
    check("bp_valid", 32'(ifa.io_out_valid), 1);
    in_valid = 1'b1;
    in_score = 16'd15;
    in_eoa   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("bp_in_ready", 32'(ifa.io_in_ready), 0);
      check("bp_hold_valid", 32'(ifa.io_out_valid), 1);
      check("bp_hold_score", 32'(ifa.io_out_score), 8);
      check("bp_hold_pos", 32'({ifa.io_out_row, ifa.io_out_col}), 1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("bp_idle_valid", 32'(ifa.io_out_valid), 0);
    check("bp_idle_ready", 32'(ifa.io_in_ready), 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_eoa   = 1'b0;
    check("bp_next_valid", 32'(ifa.io_out_valid), 1);
    check("bp_next_score", 32'(ifa.io_out_score), 15);
    check("bp_next_pos", 32'({ifa.io_out_row, ifa.io_out_col}), 0);
    handshake();

    // One row of 6 beats: COL_W=2 saturates at col 3
    beat(16'd1, 1'b0, 1'b0);
    beat(16'd2, 1'b0, 1'b0);
    beat(16'd3, 1'b0, 1'b0);
    beat(16'd4, 1'b0, 1'b0);
    beat(16'd5, 1'b0, 1'b0);
    beat(16'd6, 1'b0, 1'b1);
    check("sat_b_valid", 32'(ifb.io_out_valid), 1);
    check("sat_b_score", 32'(ifb.io_out_score), 6);
    check("sat_b_col", 32'(ifb.io_out_col), 3);
    check("sat_b_ovf", 32'(ifb.io_out_ovf), 1);
    check("sat_a_col", 32'(ifa.io_out_col), 5);
    check("sat_a_ovf", 32'(ifa.io_out_ovf), 0);
    handshake();
    check("sat_b_ovf_clr", 32'(ifb.io_out_ovf), 0);

    // Reset mid-COLLECT discards the partial alignment
    beat(16'd5, 1'b0, 1'b0);
    beat(16'd6, 1'b0, 1'b0);
    beat(16'd7, 1'b0, 1'b0);
    check("mid_busy", 32'(ifa.io_busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(ifa.io_busy), 0);
    check("mid_rst_valid", 32'(ifa.io_out_valid), 0);
    check("mid_rst_ready", 32'(ifa.io_in_ready), 1);
    check("mid_rst_score", 32'(ifa.io_out_score), 0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("mid_post_valid", 32'(ifa.io_out_valid), 0);
    beat(16'd2, 1'b0, 1'b1);
    check("mid_new_valid", 32'(ifa.io_out_valid), 1);
    check("mid_new_score", 32'(ifa.io_out_score), 2);
    check("mid_new_pos", 32'({ifa.io_out_row, ifa.io_out_col}), 0);
    check("mid_new_found", 32'(ifa.io_out_found), 1);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sw_score_collector.md
SW_SCORE_COLLECTOR -- requirements
Module: SWScoreCollector

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, meaning width of one cell score (unsigned).
REQ-002 SHALL have parameter ROW_W, default 10, meaning width of the row index.
REQ-003 SHALL have parameter COL_W, default 10, meaning width of the column index.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_in_valid  input  1  score beat from last PE of the systolic array is present.
REQ-007 io_in_ready  output  1  collector accepts the beat this cycle.
REQ-008 io_in_score  input  SCORE_W  cell score H(i,j).
REQ-009 io_in_eor  input  1  beat is the last column of the current row.
REQ-010 io_in_eoa  input  1  beat is the last cell of the alignment.
REQ-011 io_out_valid  output  1  result is available.
REQ-012 io_out_ready  input  1  downstream consumes the result.
REQ-013 io_out_score  output  SCORE_W  maximum score of the alignment.
REQ-014 io_out_row / io_out_col  output  ROW_W / COL_W  position of that maximum.
REQ-015 io_out_found  output  1  maximum score is nonzero.
REQ-016 io_out_ovf  output  1  a row or column index saturated during the alignment.
REQ-017 io_busy  output  1  state is COLLECT.

Function
REQ-018 SHALL implement states IDLE, COLLECT, RESULT.
REQ-019 Beat accepted SHALL mean io_in_valid && io_in_ready.
REQ-020 io_in_ready SHALL be 1 in IDLE and COLLECT and 0 in RESULT (combinational from state only).
REQ-021 IDLE -> COLLECT on an accepted beat without eoa; IDLE -> RESULT on an accepted beat with eoa.
REQ-022 COLLECT -> RESULT on an accepted beat with eoa; otherwise COLLECT is held.
REQ-023 RESULT -> IDLE when io_out_ready is 1; io_in_ready is first high again the cycle after the result handshake.
REQ-024 Each accepted beat SHALL carry position (row, col); the first beat of an alignment is (0,0).
REQ-025 After an accepted beat: if eor, col <= 0 and row <= row+1; otherwise col <= col+1.
REQ-026 Index counters SHALL saturate at all-ones; an increment attempted at all-ones sets the sticky ovf flag.
REQ-027 The running maximum SHALL update only when the beat score is strictly greater than the stored max, so the first occurrence wins ties.
REQ-028 At the start of an alignment (the accepted beat in IDLE), the max SHALL be initialized to 0 at (0,0) before that beat is compared.
REQ-029 The eoa beat's own score SHALL be included in the comparison.
REQ-030 Beats with both eor and eoa SHALL be legal, and eoa SHALL take precedence for the state transition.
REQ-031 io_out_valid SHALL be 1 exactly in RESULT, first asserted the cycle after the eoa beat is accepted (latency 1).
REQ-032 io_out_score/row/col/found/ovf SHALL be registered and stable while io_out_valid is 1.
REQ-033 Beats presented while in RESULT SHALL not be accepted and SHALL not alter any state.
REQ-034 After the RESULT -> IDLE transition, the row/col counters and ovf SHALL be cleared.
REQ-035 io_out_found SHALL be (max != 0).

Reset
REQ-036 Reset SHALL act asynchronously: state=IDLE, io_out_valid=0, io_busy=0, all counters, max, position, found and ovf = 0.
REQ-037 Reset asserted mid-COLLECT or mid-RESULT SHALL discard the partial or pending result with no output handshake.
REQ-038 io_in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-039 2x3 matrix, row-major scores 1,4,2 / 3,9,0 (eor on col 2, eoa on last) -> one cycle later: valid=1, score=9, row=1, col=1, found=1, ovf=0.
REQ-040 Scores 5,7,7 in a single row with eoa on the third beat -> score=7, col=1 (tie keeps first occurrence).
REQ-041 All-zero 2x2 matrix -> score=0, row=0, col=0, found=0.
REQ-042 Result pending with io_out_ready=0 for 5 cycles while io_in_valid=1 -> in_ready=0, outputs stable; then out_ready=1 -> IDLE, and the next alignment starts at (0,0).
REQ-043 COL_W=2, one row of 6 beats -> col saturates at 3, ovf=1 reported with the result.
REQ-044 Reset pulse after 3 beats of COLLECT -> IDLE, no out_valid; a new 1-beat eoa alignment with score 2 -> score=2, (0,0).
